// File: rtl/song_reader_pkg.sv
// Shared definitions for the song reader: widths, state encoding, ROM word layout
// and the song table that song_rom serves.
package song_reader_pkg;

  localparam int ROM_W   = 12;
  localparam int NOTE_W  = 6;
  localparam int DUR_W   = 6;
  localparam int SONG_W  = 2;
  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_RD     = 3'd1;
  localparam logic [STATE_W-1:0] ST_LOAD   = 3'd2;
  localparam logic [STATE_W-1:0] ST_SETTLE = 3'd3;
  localparam logic [STATE_W-1:0] ST_WAIT   = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE   = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = ST_IDLE,
    S_RD     = ST_RD,
    S_LOAD   = ST_LOAD,
    S_SETTLE = ST_SETTLE,
    S_WAIT   = ST_WAIT,
    S_DONE   = ST_DONE
  } state_e;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  duration;
  } rom_word_t;

  // A zero duration terminates a song before its last slot.
  localparam logic [DUR_W-1:0] END_MARKER = '0;

  // Song table, indexed by song select and note slot (slots beyond 255 alias).
  function automatic rom_word_t rom_word(input logic [SONG_W-1:0] song,
                                         input logic [7:0]        idx);
    rom_word_t w;
    w = '0;
    case (song)
      2'd0: begin
        if (idx == 8'd0)      w = '{note: 6'd12, duration: 6'd8};
        else if (idx == 8'd1) w = '{note: 6'd20, duration: 6'd4};
      end
      2'd1: begin
        if (idx < 8'd4) w = '{note: 6'(8'd40 + idx), duration: 6'd16};
      end
      2'd2: begin
        // Full-length song with no end marker in its first 32 slots.
        if (idx < 8'd32) w = '{note: 6'(idx + 8'd1), duration: 6'(8'd63 - idx)};
      end
      default: begin
        if (idx == 8'd0) w = '{note: 6'd63, duration: 6'd1};
      end
    endcase
    return w;
  endfunction

endpackage

// File: rtl/song_reader_if.sv
// Control and note-load bus of the song reader; master is the reader itself,
// slave is the controller / downstream note player side.
interface song_reader_if;
  import song_reader_pkg::*;

  logic              play;
  logic [SONG_W-1:0] song;
  logic              note_done;
  logic [NOTE_W-1:0] note;
  logic [DUR_W-1:0]  duration;
  logic              new_note;
  logic              song_done;

  modport master (
    input  play, song, note_done,
    output note, duration, new_note, song_done
  );

  modport slave (
    output play, song, note_done,
    input  note, duration, new_note, song_done
  );

endinterface

// File: rtl/song_rom.sv
// Song ROM with registered output: address {song, note_idx}, one-cycle latency.
module song_rom
  import song_reader_pkg::*;
#(
  parameter int ADDR_W = SONG_W + 5
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output rom_word_t         dout
);

  localparam int IDX_W = ADDR_W - SONG_W;

  logic [SONG_W-1:0] song_sel;
  logic [7:0]        idx;

  assign song_sel = addr[ADDR_W-1 -: SONG_W];
  assign idx      = 8'(addr[IDX_W-1:0]);

  // NOTE: the read register has no reset; it is reloaded every cycle and only
  // consumed one cycle after the address is set up.
  always_ff @(posedge clk) begin
    dout <= rom_word(song_sel, idx);
  end

endmodule

// File: rtl/song_reader.sv
// Song reader: steps through a ROM song, loading note/duration downstream.
// Build option: define SONG_LOOP_EN to restart the song instead of finishing.
module song_reader
  import song_reader_pkg::*;
#(
  parameter int NOTE_IDX_W = 5
) (
  input  logic          clk,
  input  logic          reset,
  song_reader_if.master bus
);

  localparam int ADDR_W = SONG_W + NOTE_IDX_W;

  logic [STATE_W-1:0]    state, state_nxt;
  logic [NOTE_IDX_W-1:0] note_idx, note_idx_nxt;
  logic [SONG_W-1:0]     song_q, song_q_nxt;
  logic [NOTE_W-1:0]     note_q, note_nxt;
  logic [DUR_W-1:0]      duration_q, duration_nxt;
  logic                  new_note_q, new_note_nxt;
  logic                  song_done_q, song_done_nxt;

  rom_word_t             rom_dout;
  logic                  song_change;
  logic                  last_slot;

  song_rom #(
    .ADDR_W (ADDR_W)
  ) u_rom (
    .clk  (clk),
    .addr ({song_q, note_idx}),
    .dout (rom_dout)
  );

  assign song_change = (bus.song != song_q);
  assign last_slot   = (note_idx == {NOTE_IDX_W{1'b1}});

  // NOTE: every variable gets a default at the top of always_comb so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt     = state;
    note_idx_nxt  = note_idx;
    song_q_nxt    = song_q;
    note_nxt      = note_q;
    duration_nxt  = duration_q;
    new_note_nxt  = 1'b0;
    song_done_nxt = song_done_q;

    if (!bus.play) begin
      // Paused: everything, including a pending strobe, is held until resume.
      new_note_nxt = new_note_q;
    end else if (song_change) begin
      song_q_nxt    = bus.song;
      note_idx_nxt  = '0;
      song_done_nxt = 1'b0;
      state_nxt     = ST_RD;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_RD;
        ST_RD:   state_nxt = ST_LOAD;
        ST_LOAD: begin
          if (rom_dout.duration == END_MARKER) begin
`ifdef SONG_LOOP_EN
            note_idx_nxt  = '0;
            state_nxt     = ST_RD;
`else
            song_done_nxt = 1'b1;
            state_nxt     = ST_DONE;
`endif
          end else begin
            new_note_nxt = 1'b1;
            note_nxt     = rom_dout.note;
            duration_nxt = rom_dout.duration;
            state_nxt    = ST_SETTLE;
          end
        end
        // Downstream done flag is still high from the previous note here.
        ST_SETTLE: state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (bus.note_done) begin
            note_idx_nxt = note_idx + NOTE_IDX_W'(1);
            if (last_slot) begin
`ifdef SONG_LOOP_EN
              note_idx_nxt  = '0;
              state_nxt     = ST_RD;
`else
              song_done_nxt = 1'b1;
              state_nxt     = ST_DONE;
`endif
            end else begin
              state_nxt = ST_RD;
            end
          end
        end
        ST_DONE: state_nxt = ST_DONE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      note_idx    <= '0;
      song_q      <= bus.song;
      note_q      <= '0;
      duration_q  <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      note_idx    <= note_idx_nxt;
      song_q      <= song_q_nxt;
      note_q      <= note_nxt;
      duration_q  <= duration_nxt;
      new_note_q  <= new_note_nxt;
      song_done_q <= song_done_nxt;
    end
  end

  assign bus.note      = note_q;
  assign bus.duration  = duration_q;
  // A strobe caught by a pause stays hidden and is released on resume.
  assign bus.new_note  = new_note_q & bus.play;
  assign bus.song_done = song_done_q;

endmodule

// File: tb/tb_song_reader.sv
// Directed self-checking bench for song_reader against the package song table.
module tb_song_reader;
  import song_reader_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   strobe_cnt = 0;
  int   bad_play = 0;
  int   cyc;

  song_reader_if bus();

  song_reader #(
    .NOTE_IDX_W (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.new_note === 1'b1) strobe_cnt++;
    if (bus.new_note === 1'b1 && bus.play !== 1'b1) bad_play++;
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Steps until the load strobe is visible; returns edges taken.
  task automatic wait_strobe(input string tag, input int budget, output int cycles);
    cycles = 0;
    do begin
      step(1);
      cycles++;
    end while (bus.new_note !== 1'b1 && cycles < budget);
    check({tag, " strobe seen"}, 32'(bus.new_note), 32'd1);
  endtask

  initial begin
    reset         = 1'b1;
    bus.play      = 1'b0;
    bus.song      = 2'd0;
    bus.note_done = 1'b1;
    step(2);
    check("reset note", 32'(bus.note), 0);
    check("reset duration", 32'(bus.duration), 0);
    check("reset new_note", 32'(bus.new_note), 0);
    check("reset song_done", 32'(bus.song_done), 0);
    reset = 1'b0;
    step(3);
    check("idle no strobe", 32'(strobe_cnt), 0);

    // First note of song 0, then the second after a downstream note_done.
    bus.play = 1'b1;
    wait_strobe("first", 10, cyc);
    check("first latency", 32'(cyc), 3);
    check("first note", 32'(bus.note), 12);
    check("first duration", 32'(bus.duration), 8);
    step(1);
    check("strobe one cycle", 32'(bus.new_note), 0);
    bus.note_done = 1'b0;
    step(10);
    check("one strobe per note", 32'(strobe_cnt), 1);
    check("note held", 32'(bus.note), 12);
    bus.note_done = 1'b1;
    wait_strobe("second", 10, cyc);
    check("second latency", 32'(cyc), 3);
    check("second note", 32'(bus.note), 20);
    check("second duration", 32'(bus.duration), 4);

    // Slot 2 is the end marker: song finishes without a third strobe.
    step(3);
    check("done not yet", 32'(bus.song_done), 0);
    step(1);
    check("song0 done", 32'(bus.song_done), 1);
    step(5);
    check("no third strobe", 32'(strobe_cnt), 2);
    check("done note held", 32'(bus.note), 20);
    check("done duration held", 32'(bus.duration), 4);

    // Song change out of DONE restarts song 3 from slot 0.
    bus.song = 2'd3;
    step(1);
    check("change clears done", 32'(bus.song_done), 0);
    wait_strobe("song3", 10, cyc);
    check("song3 latency", 32'(cyc), 2);
    check("song3 note", 32'(bus.note), 63);
    check("song3 duration", 32'(bus.duration), 1);
    step(4);
    check("song3 done", 32'(bus.song_done), 1);

    // Mid-note change from song 0 to song 1.
    bus.song      = 2'd0;
    bus.note_done = 1'b0;
    wait_strobe("song0 again", 10, cyc);
    check("song0 again note", 32'(bus.note), 12);
    step(4);
    bus.song = 2'd1;
    wait_strobe("song1", 10, cyc);
    check("song1 latency", 32'(cyc), 3);
    check("song1 note", 32'(bus.note), 40);
    check("song1 duration", 32'(bus.duration), 16);
    check("song1 not done", 32'(bus.song_done), 0);

    // Pause in WAIT with note_done high: no advance until play returns.
    step(1);
    bus.play      = 1'b0;
    bus.note_done = 1'b1;
    step(20);
    check("pause no strobe", 32'(strobe_cnt), 5);
    check("pause note held", 32'(bus.note), 40);
    bus.play = 1'b1;
    wait_strobe("resume", 10, cyc);
    check("resume latency", 32'(cyc), 3);
    check("resume note", 32'(bus.note), 41);

    // Reset mid-note abandons it; next play starts at slot 0 again.
    step(1);
    bus.note_done = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
    check("midreset note", 32'(bus.note), 0);
    check("midreset duration", 32'(bus.duration), 0);
    check("midreset new_note", 32'(bus.new_note), 0);
    reset = 1'b0;
    wait_strobe("after reset", 10, cyc);
    check("after reset latency", 32'(cyc), 3);
    check("after reset note", 32'(bus.note), 40);

    // Song 2 fills all 32 slots with no end marker.
    step(1);
    bus.song = 2'd2;
    for (int i = 0; i < 32; i++) begin
      wait_strobe("song2", 10, cyc);
      check("song2 latency", 32'(cyc), 3);
      check("song2 note", 32'(bus.note), 32'(i + 1));
      check("song2 duration", 32'(bus.duration), 32'(63 - i));
      bus.note_done = 1'b1;
      step(1);
    end
`ifdef SONG_LOOP_EN
    wait_strobe("loop", 10, cyc);
    check("loop latency", 32'(cyc), 3);
    check("loop note", 32'(bus.note), 1);
    check("loop duration", 32'(bus.duration), 63);
    check("loop not done", 32'(bus.song_done), 0);
    step(1);
    check("total strobes", 32'(strobe_cnt), 40);
`else
    step(1);
    check("song2 done", 32'(bus.song_done), 1);
    step(3);
    check("song2 idle strobe", 32'(bus.new_note), 0);
    check("total strobes", 32'(strobe_cnt), 39);
`endif
    check("strobe while paused", 32'(bad_play), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/song_reader.md
SONG_READER -- requirements
Module: song_reader

Interface
REQ-001 SHALL have parameter NOTE_IDX_W, default 5, meaning log2 of note slots per song (32).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port play  input  1  high = advance through song; low = freeze.
REQ-005 SHALL have port song  input  2  song select, one of 4 songs.
REQ-006 SHALL have port note_done  input  1  downstream note player finished current note (level).
REQ-007 SHALL have port note  output  6  note code to load downstream.
REQ-008 SHALL have port duration  output  6  duration in 1/48 s beats to load downstream.
REQ-009 SHALL have port new_note  output  1  one-cycle load strobe for note/duration.
REQ-010 SHALL have port song_done  output  1  level, song finished.

Function
REQ-011 SHALL read ROM word {note[11:6], duration[5:0]} at address {song, note_idx}; ROM output is registered, 1-cycle read latency.
REQ-012 SHALL implement states IDLE, RD, LOAD, SETTLE, WAIT, DONE.
REQ-013 IDLE: play=1 -> RD; else stay.
REQ-014 RD: ROM address valid; next cycle -> LOAD.
REQ-015 LOAD: if ROM duration==0 (end marker) -> DONE with no strobe; else new_note=1 for exactly this cycle, note/duration register ROM data, -> SETTLE.
REQ-016 SETTLE: one cycle, ignores note_done (downstream done flag drops one cycle after load) -> WAIT.
REQ-017 WAIT: note_done=1 -> note_idx+1, -> RD; if note_idx was 2^NOTE_IDX_W-1 -> DONE.
REQ-018 DONE: song_done=1; held until reset or song change.
REQ-019 play=0 SHALL freeze state, note_idx and outputs; new_note SHALL never assert while play=0; a LOAD cycle coinciding with play=0 is deferred until play=1.
REQ-020 Latency: play sampled high in IDLE at edge N -> new_note high during cycle after edge N+2.
REQ-021 A change of song (compared against registered previous value) SHALL clear note_idx, clear song_done, and force RD next cycle, overriding all other transitions in that cycle; when play=0 the restart occurs once play returns high.
REQ-022 note/duration outputs SHALL hold their last loaded values between strobes.

Reset
REQ-023 reset SHALL force state IDLE, note_idx=0, note=0, duration=0, new_note=0, song_done=0, registered song = current song input.
REQ-024 reset mid-note SHALL abandon the note; the next play restarts at note_idx 0.

Configuration
REQ-025 Macro SONG_LOOP_EN: when defined, entry to DONE instead sets note_idx=0 and goes to RD, song_done stays 0.
REQ-026 Without SONG_LOOP_EN: behaviour per REQ-018.

Structure
REQ-027 Shared package SHALL hold state enum, ROM word width (12), note/duration widths (6), song select width (2).
REQ-028 Sub-module song_rom SHALL contain the ROM (registered output, addr 7 bits, dout 12 bits).

Verification
REQ-029 Reset, play=1, song=0, ROM[0]={12,8} -> new_note pulse 2 cycles after play, note=12, duration=8.
REQ-030 Hold note_done=1 through SETTLE, drop after, raise 10 cycles later -> exactly one strobe per note, next note strobed 2 cycles after note_done rise.
REQ-031 ROM[2] duration=0 -> two notes played, then song_done=1, no third strobe.
REQ-032 Drop play for 20 cycles while in WAIT with note_done=1 -> no advance; resume -> advance to next note.
REQ-033 Change song 0->1 mid-note -> next strobe carries ROM[32] data, song_done=0.
REQ-034 Song with no end marker, 32 notes -> song_done after 32nd note_done; with SONG_LOOP_EN -> 33rd strobe carries note_idx 0 data.
